// File: rtl/fp_minmax_stream.sv
// Streaming min/max reducer over packets of IEEE754 single-precision values.
// Define FP_MINMAX_NAN_EN to screen NaNs out of the ordering and add nan_seen_o.
module fp_minmax_stream #(
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      min_val_o,
  output logic [31:0]      max_val_o,
  output logic [IDX_W-1:0] min_idx_o,
  output logic [IDX_W-1:0] max_idx_o,
  output logic [IDX_W-1:0] count_o,
  output logic             ovf_o
`ifdef FP_MINMAX_NAN_EN
  ,
  output logic             nan_seen_o
`endif
);

  typedef enum logic [1:0] {StFirst, StAccum, StHold} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [31:0]      min_q;
  logic [31:0]      max_q;
  logic [IDX_W-1:0] min_idx_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] count_q;
  logic [IDX_W-1:0] count_d;
  logic             ovf_q;
  logic             in_fire;
  logic             upd_min;
  logic             upd_max;

  // Sign-magnitude "a < b"; +0 and -0 compare equal.
  function automatic logic fp_lt(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == '0 && b[30:0] == '0) return 1'b0;
    if (a[31] != b[31]) return a[31];
    return a[31] ? (a[30:0] > b[30:0]) : (a[30:0] < b[30:0]);
  endfunction

  assign in_fire = in_valid_i && in_ready_q;
  assign count_d = count_q + IDX_W'(1);

`ifdef FP_MINMAX_NAN_EN
  logic is_nan;
  logic nan_seen_q;
  logic nan_only_q;  // every element so far was NaN; next real value seeds both extremes

  assign is_nan  = (in_data_i[30:23] == 8'hFF) && (in_data_i[22:0] != '0);
  assign upd_min = !is_nan && (nan_only_q || fp_lt(in_data_i, min_q));
  assign upd_max = !is_nan && (nan_only_q || fp_lt(max_q, in_data_i));
  assign nan_seen_o = nan_seen_q;
`else
  assign upd_min = fp_lt(in_data_i, min_q);
  assign upd_max = fp_lt(max_q, in_data_i);
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StFirst;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      min_q       <= '0;
      max_q       <= '0;
      min_idx_q   <= '0;
      max_idx_q   <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
`ifdef FP_MINMAX_NAN_EN
      nan_seen_q  <= 1'b0;
      nan_only_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFirst: begin
          if (in_fire) begin
            min_q     <= in_data_i;
            max_q     <= in_data_i;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= IDX_W'(1);
            ovf_q     <= 1'b0;
`ifdef FP_MINMAX_NAN_EN
            nan_seen_q <= is_nan;
            nan_only_q <= is_nan;
`endif
            if (in_last_i) begin
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StAccum;
            end
          end
        end
        StAccum: begin
          if (in_fire) begin
            if (upd_min) begin
              min_q     <= in_data_i;
              min_idx_q <= count_q;
            end
            if (upd_max) begin
              max_q     <= in_data_i;
              max_idx_q <= count_q;
            end
`ifdef FP_MINMAX_NAN_EN
            if (is_nan) nan_seen_q <= 1'b1;
            else        nan_only_q <= 1'b0;
`endif
            count_q <= count_d;
            if (count_q == '1) ovf_q <= 1'b1;
            if (in_last_i) begin
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready_i) begin
            state_q     <= StFirst;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef FP_MINMAX_NAN_EN
            nan_seen_q  <= 1'b0;
`endif
          end
        end
        default: state_q <= StFirst;
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign min_val_o   = min_q;
  assign max_val_o   = max_q;
  assign min_idx_o   = min_idx_q;
  assign max_idx_o   = max_idx_q;
  assign count_o     = count_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fp_minmax_stream.sv
// Randomized packet bench for fp_minmax_stream; two instances (IDX_W 16 and 2) share stimulus
// and are checked against an integer-key reference model.
module tb_fp_minmax_stream;

`ifdef FP_MINMAX_NAN_EN
  localparam bit NanEn = 1'b1;
`else
  localparam bit NanEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        rdy_a, ov_a, ovf_a, rdy_b, ov_b, ovf_b;
  logic [31:0] mn_a, mx_a, mn_b, mx_b;
  logic [15:0] mni_a, mxi_a, cnt_a;
  logic [1:0]  mni_b, mxi_b, cnt_b;
`ifdef FP_MINMAX_NAN_EN
  logic        nan_a, nan_b;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] pkt_q[$];

  typedef struct packed {
    logic [31:0] mn;
    logic [31:0] mx;
    logic [31:0] mni;
    logic [31:0] mxi;
    logic [31:0] cnt;
    logic        ovf;
    logic        nan;
  } res_t;

  always #5 clk = ~clk;

  fp_minmax_stream #(.IDX_W(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_a),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(ov_a), .out_ready_i(out_ready),
    .min_val_o(mn_a), .max_val_o(mx_a), .min_idx_o(mni_a), .max_idx_o(mxi_a),
    .count_o(cnt_a), .ovf_o(ovf_a)
`ifdef FP_MINMAX_NAN_EN
    , .nan_seen_o(nan_a)
`endif
  );

  fp_minmax_stream #(.IDX_W(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy_b),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(ov_b), .out_ready_i(out_ready),
    .min_val_o(mn_b), .max_val_o(mx_b), .min_idx_o(mni_b), .max_idx_o(mxi_b),
    .count_o(cnt_b), .ovf_o(ovf_b)
`ifdef FP_MINMAX_NAN_EN
    , .nan_seen_o(nan_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else n_pass++;
  endtask

  // Total-order key: negative values map below zero, both zeros map to 0.
  function automatic longint key(input logic [31:0] x);
    longint mag;
    mag = longint'(x[30:0]);
    return x[31] ? -mag : mag;
  endfunction

  function automatic res_t model(input int w);
    res_t r;
    bit   have;
    int   n, m;
    r = '0;
    have = 1'b0;
    n = pkt_q.size();
    m = 1 << w;
    for (int i = 0; i < n; i++) begin
      logic [31:0] e;
      e = pkt_q[i];
      if (NanEn && e[30:23] == 8'hFF && e[22:0] != 0) begin
        r.nan = 1'b1;
        continue;
      end
      if (!have || key(e) < key(r.mn)) begin r.mn = e; r.mni = i % m; end
      if (!have || key(e) > key(r.mx)) begin r.mx = e; r.mxi = i % m; end
      have = 1'b1;
    end
    if (!have) begin
      r.mn = pkt_q[0];
      r.mx = pkt_q[0];
    end
    r.cnt = n % m;
    r.ovf = (n >= m);
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    res_t ra, rb;
    ra = model(16);
    rb = model(2);
    check({tag, "_ov"}, {ov_a, ov_b}, 2'b11);
    check({tag, "_rdy"}, {rdy_a, rdy_b}, 2'b00);
    check({tag, "_min16"}, {mn_a, 16'(0), mni_a}, {ra.mn, 16'(0), ra.mni[15:0]});
    check({tag, "_max16"}, {mx_a, 16'(0), mxi_a}, {ra.mx, 16'(0), ra.mxi[15:0]});
    check({tag, "_cnt16"}, {ovf_a, cnt_a}, {ra.ovf, ra.cnt[15:0]});
    check({tag, "_min2"}, {mn_b, mni_b}, {rb.mn, rb.mni[1:0]});
    check({tag, "_max2"}, {mx_b, mxi_b}, {rb.mx, rb.mxi[1:0]});
    check({tag, "_cnt2"}, {ovf_b, cnt_b}, {rb.ovf, rb.cnt[1:0]});
`ifdef FP_MINMAX_NAN_EN
    check({tag, "_nan"}, {nan_a, nan_b}, {ra.nan, rb.nan});
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {rdy_a, ov_a, rdy_b, ov_b}, 4'b1010);
    check({tag, "_a"}, {mn_a, mx_a, mni_a, mxi_a, cnt_a, ovf_a} == '0, 1'b1);
    check({tag, "_b"}, {mn_b, mx_b, mni_b, mxi_b, cnt_b, ovf_b} == '0, 1'b1);
`ifdef FP_MINMAX_NAN_EN
    check({tag, "_nan"}, {nan_a, nan_b}, 2'b00);
`endif
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that drops out_valid.
  task automatic send_pkt(input int hold, input bit early);
    out_ready = early;
    for (int i = 0; i < pkt_q.size(); i++) begin
      while ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = pkt_q[i];
      in_last  = (i == pkt_q.size() - 1);
      for (int t = 0; t < 50 && !rdy_a; t++) begin
        @(posedge clk); #1;
      end
      check("in_rdy", {rdy_a, rdy_b, ov_a}, 3'b110);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_outputs("res");
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check_outputs("hold");
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release", {ov_a, ov_b, rdy_a, rdy_b}, 4'b0011);
`ifdef FP_MINMAX_NAN_EN
    check("nan_clr", {nan_a, nan_b}, 2'b00);
`endif
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7F80_0000;
      3:       return 32'hFF80_0000;
      4:       return 32'h3F80_0000;
      5:       return 32'hBF80_0000;
      6:       return 32'h7FC0_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    pkt_q = '{32'h3F80_0000, 32'hC000_0000, 32'h3F00_0000};
    send_pkt(1, 1'b0);
    pkt_q = '{32'h8000_0000, 32'h0000_0000};
    send_pkt(0, 1'b1);
    pkt_q = '{32'h7F80_0000};
    send_pkt(5, 1'b0);
    pkt_q = '{32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 32'h3F00_0000, 32'h4080_0000};
    send_pkt(2, 1'b0);

    // Abort a packet with reset after two elements.
    in_valid = 1'b1; in_data = 32'h4100_0000; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 32'hC100_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset("mid_rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pkt_q = '{32'h4120_0000};
    send_pkt(1, 1'b0);

`ifdef FP_MINMAX_NAN_EN
    pkt_q = '{32'h7FC0_0000, 32'h3F80_0000, 32'hBF80_0000};
    send_pkt(1, 1'b0);
    pkt_q = '{32'h7FC0_0001, 32'hFFC0_0000};
    send_pkt(1, 1'b0);
`endif

    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 9);
      pkt_q.delete();
      for (int i = 0; i < len; i++) pkt_q.push_back(rand_val());
      send_pkt($urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
